usec_timebase: RTL and testbench

Free-running microsecond time base that produces the 32-bit `usec` count consumed by the start-time comparator, which fires `start` when `usec` equals the programmed start time. It divides `clk` down to 1 µs ticks and accepts a software time load, applied either immediately or at the next external PPS edge. It captures `usec` at every PPS edge and flags PPS loss, so software can set and check absolute time before programming start instants.

---
 rtl/usec_timebase.sv | 169 ++++++++++++++++
 tb/tb_usec_timebase.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/usec_timebase.sv
// Free-running microsecond time base with immediate or PPS-aligned time load,
// PPS capture, and a sticky PPS-loss watchdog.
module usec_timebase #(
    parameter int unsigned CLK_PER_US     = 100,
    parameter int unsigned PPS_TIMEOUT_US = 1100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pps,
    input  logic        we_t,
    input  logic [31:0] t_load,
    input  logic        arm_sync,
    output logic [31:0] usec,
    output logic        tick_us,
    output logic [31:0] pps_cap,
    output logic        pps_seen,
    output logic        armed,
    output logic        pps_lost
);

    localparam logic [15:0] PRE_MAX = 16'(CLK_PER_US - 1);
    localparam logic [23:0] WD_MAX  = 24'(PPS_TIMEOUT_US);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [15:0] r_pre;
    logic [31:0] r_usec;
    logic        r_tick;
    logic [31:0] r_shadow;
    logic [0:0]  r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [1:0]  r_warm;
    logic        r_pps_ok;
    logic [23:0] r_wdog;
    logic        r_lost;
    logic [31:0] r_cap;
    logic        r_seen;

    logic        w_pe;
    logic        w_pre_wrap;
    logic        w_load;
    logic [31:0] w_load_val;
    logic [0:0]  w_state_d;
    logic [31:0] w_shadow_d;
    logic [15:0] w_pre_d;
    logic [31:0] w_usec_d;
    logic        w_tick_d;
    logic [23:0] w_wdog_d;
    logic        w_lost_d;

    // Edges only count once the synchronizer has seen pps low after reset, so a
    // pps already high at reset release does not look like a rising edge.
    assign w_pe       = r_sync2 & ~r_sync3 & r_pps_ok;
    assign w_pre_wrap = (r_pre == PRE_MAX);

    always_comb begin
        w_state_d  = r_state;
        w_shadow_d = r_shadow;
        w_load     = 1'b0;
        w_load_val = t_load;
        case (r_state)
            ST_RUN: begin
                if (we_t) begin
                    if (arm_sync) begin
                        w_shadow_d = t_load;
                        w_state_d  = ST_ARMED;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                // A software write beats a same-cycle PPS edge.
                if (we_t) begin
                    if (arm_sync) begin
                        w_shadow_d = t_load;
                    end else begin
                        w_load    = 1'b1;
                        w_state_d = ST_RUN;
                    end
                end else if (w_pe) begin
                    w_load     = 1'b1;
                    w_load_val = r_shadow;
                    w_state_d  = ST_RUN;
                end
            end
            default: w_state_d = ST_RUN;
        endcase
    end

    always_comb begin
        w_pre_d  = r_pre + 16'd1;
        w_usec_d = r_usec;
        w_tick_d = 1'b0;
        if (w_load) begin
            w_pre_d  = 16'd0;
            w_usec_d = w_load_val;
        end else if (w_pre_wrap) begin
            w_pre_d  = 16'd0;
            w_usec_d = r_usec + 32'd1;
            w_tick_d = 1'b1;
        end
    end

    always_comb begin
        w_wdog_d = r_wdog;
        if (w_pe) begin
            w_wdog_d = 24'd0;
        end else if (w_tick_d && (r_wdog != WD_MAX)) begin
            w_wdog_d = r_wdog + 24'd1;
        end
        w_lost_d = w_pe ? 1'b0 : (r_lost | (w_wdog_d == WD_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_warm   <= 2'd0;
            r_pps_ok <= 1'b0;
        end else begin
            r_sync1  <= pps;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end
            r_pps_ok <= r_pps_ok | ((r_warm == 2'd2) & ~r_sync2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= 16'd0;
            r_usec   <= 32'd0;
            r_tick   <= 1'b0;
            r_shadow <= 32'd0;
            r_state  <= ST_RUN;
            r_wdog   <= 24'd0;
            r_lost   <= 1'b0;
            r_cap    <= 32'd0;
            r_seen   <= 1'b0;
        end else begin
            r_pre    <= w_pre_d;
            r_usec   <= w_usec_d;
            r_tick   <= w_tick_d;
            r_shadow <= w_shadow_d;
            r_state  <= w_state_d;
            r_wdog   <= w_wdog_d;
            r_lost   <= w_lost_d;
            r_seen   <= w_pe;
            if (w_pe) begin
                r_cap <= r_usec;
            end
        end
    end

    assign usec     = r_usec;
    assign tick_us  = r_tick;
    assign pps_cap  = r_cap;
    assign pps_seen = r_seen;
    assign armed    = (r_state == ST_ARMED);
    assign pps_lost = r_lost;

endmodule

// File: tb/tb_usec_timebase.sv
// Directed table-driven bench for usec_timebase with CLK_PER_US=4, PPS_TIMEOUT_US=10.
module tb_usec_timebase;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pps = 1'b0;
    logic        we_t = 1'b0;
    logic [31:0] t_load = 32'd0;
    logic        arm_sync = 1'b0;
    logic [31:0] usec;
    logic        tick_us;
    logic [31:0] pps_cap;
    logic        pps_seen;
    logic        armed;
    logic        pps_lost;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    usec_timebase #(
        .CLK_PER_US     (4),
        .PPS_TIMEOUT_US (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pps      (pps),
        .we_t     (we_t),
        .t_load   (t_load),
        .arm_sync (arm_sync),
        .usec     (usec),
        .tick_us  (tick_us),
        .pps_cap  (pps_cap),
        .pps_seen (pps_seen),
        .armed    (armed),
        .pps_lost (pps_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned n;
        logic        we;
        logic [31:0] tl;
        logic        as;
        logic        pps;
        logic [31:0] eu;
        logic        et;
        logic        ea;
        logic        es;
        logic        el;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input string nm, input int unsigned n, input logic we,
                                input logic [31:0] tl, input logic as, input logic p,
                                input logic [31:0] eu, input logic et, input logic ea,
                                input logic es, input logic el, input logic [31:0] ec);
        vec_t v;
        v.name = nm; v.n = n; v.we = we; v.tl = tl; v.as = as; v.pps = p;
        v.eu = eu; v.et = et; v.ea = ea; v.es = es; v.el = el; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".usec"}, usec, 32'd0);
        chk({tag, ".tick"}, {31'd0, tick_us}, 32'd0);
        chk({tag, ".cap"}, pps_cap, 32'd0);
        chk({tag, ".seen"}, {31'd0, pps_seen}, 32'd0);
        chk({tag, ".armed"}, {31'd0, armed}, 32'd0);
        chk({tag, ".lost"}, {31'd0, pps_lost}, 32'd0);
    endtask

    initial begin
        int unsigned seen_cnt;

        //          name         n  we tl            as pps eu            et ea es el ec
        tbl[0]  = mk("idle3",    3, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0);
        tbl[1]  = mk("inc1",     1, 0, 0,            0, 0, 1,            1, 0, 0, 0, 0);
        tbl[2]  = mk("hold1",    1, 0, 0,            0, 0, 1,            0, 0, 0, 0, 0);
        tbl[3]  = mk("to9",     31, 0, 0,            0, 0, 9,            1, 0, 0, 0, 0);
        tbl[4]  = mk("to10",     4, 0, 0,            0, 0, 10,           1, 0, 0, 1, 0);
        tbl[5]  = mk("ld_fe",    1, 1, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 0);
        tbl[6]  = mk("fe_hold",  3, 0, 0,            0, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 0);
        tbl[7]  = mk("to_ff",    1, 0, 0,            0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 0);
        tbl[8]  = mk("wrap0",    4, 0, 0,            0, 0, 0,            1, 0, 0, 1, 0);
        tbl[9]  = mk("ld4_to5",  5, 1, 4,            0, 0, 5,            1, 0, 0, 1, 0);
        tbl[10] = mk("arm1000",  1, 1, 1000,         1, 0, 5,            0, 1, 0, 1, 0);
        tbl[11] = mk("arm_run",  8, 0, 0,            0, 0, 7,            0, 1, 0, 1, 0);
        tbl[12] = mk("pps_sync", 2, 0, 0,            0, 1, 7,            0, 1, 0, 1, 0);
        tbl[13] = mk("pps_load", 1, 0, 0,            0, 1, 1000,         0, 0, 1, 0, 7);
        tbl[14] = mk("pps_hi",   1, 0, 0,            0, 1, 1000,         0, 0, 0, 0, 7);
        tbl[15] = mk("pps_lo",   1, 0, 0,            0, 0, 1000,         0, 0, 0, 0, 7);
        tbl[16] = mk("arm55",    1, 1, 55,           1, 0, 1000,         0, 1, 0, 0, 7);
        tbl[17] = mk("arm66",    1, 1, 66,           1, 0, 1001,         1, 1, 0, 0, 7);
        tbl[18] = mk("pps2_syn", 2, 0, 0,            0, 1, 1001,         0, 1, 0, 0, 7);
        tbl[19] = mk("we_vs_pe", 1, 1, 7,            0, 1, 7,            0, 0, 1, 0, 1001);
        tbl[20] = mk("no_shad",  4, 0, 0,            0, 1, 8,            1, 0, 0, 0, 1001);
        tbl[21] = mk("pps2_lo",  1, 0, 0,            0, 0, 8,            0, 0, 0, 0, 1001);
        tbl[22] = mk("re_arm55", 1, 1, 55,           1, 0, 8,            0, 1, 0, 0, 1001);
        tbl[23] = mk("re_arm66", 1, 1, 66,           1, 0, 8,            0, 1, 0, 0, 1001);
        tbl[24] = mk("pps3_ld",  3, 0, 0,            0, 1, 66,           0, 0, 1, 0, 9);
        tbl[25] = mk("pps3_lo",  1, 0, 0,            0, 0, 66,           0, 0, 0, 0, 9);

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            we_t     = tbl[i].we;
            t_load   = tbl[i].tl;
            arm_sync = tbl[i].as;
            pps      = tbl[i].pps;
            @(negedge clk);
            we_t = 1'b0;
            repeat (tbl[i].n - 1) @(negedge clk);
            chk({tbl[i].name, ".usec"}, usec, tbl[i].eu);
            chk({tbl[i].name, ".tick"}, {31'd0, tick_us}, {31'd0, tbl[i].et});
            chk({tbl[i].name, ".armed"}, {31'd0, armed}, {31'd0, tbl[i].ea});
            chk({tbl[i].name, ".seen"}, {31'd0, pps_seen}, {31'd0, tbl[i].es});
            chk({tbl[i].name, ".lost"}, {31'd0, pps_lost}, {31'd0, tbl[i].el});
            chk({tbl[i].name, ".cap"}, pps_cap, tbl[i].ec);
        end

        // Armed with a lost PPS, then reset mid-operation.
        we_t = 1'b1; t_load = 500; arm_sync = 1'b0;
        @(negedge clk);
        t_load = 1000; arm_sync = 1'b1;
        @(negedge clk);
        we_t = 1'b0; arm_sync = 1'b0;
        repeat (44) @(negedge clk);
        chk("pre_rst.usec", usec, 511);
        chk("pre_rst.armed", {31'd0, armed}, 32'd1);
        chk("pre_rst.lost", {31'd0, pps_lost}, 32'd1);

        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst.usec", usec, 2);
        chk("post_rst.tick", {31'd0, tick_us}, 32'd1);
        pps = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_pps.seen", {31'd0, pps_seen}, 32'd1);
        chk("post_rst_pps.usec", usec, 2);
        chk("post_rst_pps.armed", {31'd0, armed}, 32'd0);
        chk("post_rst_pps.cap", pps_cap, 2);
        @(negedge clk);
        chk("post_rst_pps.seen_end", {31'd0, pps_seen}, 32'd0);
        chk("post_rst_pps.usec_inc", usec, 3);

        // pps already high at reset release must not produce an edge.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (pps_seen) seen_cnt++;
        end
        chk("pps_hi_release.seen_cnt", seen_cnt, 0);
        pps = 1'b0;
        repeat (4) @(negedge clk);
        pps = 1'b1;
        repeat (3) @(negedge clk);
        chk("pps_relo_hi.seen", {31'd0, pps_seen}, 32'd1);
        chk("pps_relo_hi.cap", pps_cap, 4);
        chk("pps_relo_hi.usec", usec, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
